// File: rtl/sprite_layer_scaled_if.sv
// Pixel-stream, sprite-control and sprite-ROM signals between the video timing side
// and one scaled sprite layer.
interface sprite_layer_scaled_if #(
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned ROM_AW  = 13,
    parameter int unsigned FRAME_W = 2
);
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               blank;
    logic [9:0]         pos_x;
    logic [9:0]         pos_y;
    logic [1:0]         scale;
    logic               anim_en;
    logic [5:0]         frame_hold;
    logic [ROM_AW-1:0]  rom_addr;
    logic [IDX_W-1:0]   rom_data;
    logic [IDX_W-1:0]   pix_idx;
    logic               pix_opaque;
    logic [FRAME_W-1:0] anim_frame;

    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, scale, anim_en, frame_hold, rom_data,
        input  rom_addr, pix_idx, pix_opaque, anim_frame
    );

    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, scale, anim_en, frame_hold, rom_data,
        output rom_addr, pix_idx, pix_opaque, anim_frame
    );
endinterface

// File: rtl/sprite_layer_scaled.sv
// One animated, integer-scaled sprite layer: counter-based texel tracking, ROM
// addressing and a 3-cycle pipeline to a registered palette index / opacity.
module sprite_layer_scaled #(
    parameter int unsigned SPR_W      = 42,
    parameter int unsigned SPR_H      = 44,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned KEY_IDX    = 0,
    parameter int unsigned ROM_AW     = 13
) (
    input logic                  vga_clk,
    input logic                  reset,
    sprite_layer_scaled_if.slave bus
);
    localparam int unsigned FRAME_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int unsigned COL_W    = $clog2(SPR_W);
    localparam int unsigned ROW_W    = $clog2(SPR_H);
    localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

    logic [9:0]         prev_x_q, prev_x_d;
    logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]         scale_q, scale_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         row_sub_q, row_sub_d;
    logic               in_rows_q, in_rows_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [1:0]         col_sub_q, col_sub_d;
    logic               in_cols_q, in_cols_d;
    logic [5:0]         hold_q, hold_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               v1_q, v1_d, v2_q, v2_d;
    logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
    logic               pix_opaque_q, pix_opaque_d;

    logic               line_start_c, frame_start_c;
    logic               in_cols_c;
    logic [COL_W-1:0]   col_c;
    logic [1:0]         col_sub_c;
    logic               hit_c;

    // The _d values of frame, row and latched controls are also the values in force this cycle.
    always_comb begin
        line_start_c  = (bus.DrawX == 10'd0) && (prev_x_q != 10'd0);
        frame_start_c = line_start_c && (bus.DrawY == 10'd0);
        prev_x_d      = bus.DrawX;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        scale_d       = scale_q;
        hold_d        = hold_q;
        frame_d       = frame_q;
        row_d         = row_q;
        row_sub_d     = row_sub_q;
        in_rows_d     = in_rows_q;

        if (frame_start_c) begin
            pos_x_d   = bus.pos_x;
            pos_y_d   = bus.pos_y;
            scale_d   = bus.scale;
            row_d     = '0;
            row_sub_d = '0;
            in_rows_d = 1'b0;
            if (bus.anim_en) begin
                if (hold_q == bus.frame_hold) begin
                    hold_d  = '0;
                    frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
                end else begin
                    hold_d = hold_q + 6'd1;
                end
            end
        end

        if (line_start_c) begin
            if (bus.DrawY == pos_y_d) begin
                in_rows_d = 1'b1;
                row_d     = '0;
                row_sub_d = '0;
            end else if (in_rows_d) begin
                if (row_sub_d == scale_d) begin
                    row_sub_d = '0;
                    if (row_d == ROW_W'(SPR_H - 1)) in_rows_d = 1'b0;
                    else                             row_d     = row_d + ROW_W'(1);
                end else begin
                    row_sub_d = row_sub_d + 2'd1;
                end
            end
        end

        // Column state for this pixel, then its advance for the next one.
        in_cols_c = in_cols_q && !line_start_c;
        col_c     = col_q;
        col_sub_c = col_sub_q;
        if ((bus.DrawX == pos_x_d) && in_rows_d) begin
            in_cols_c = 1'b1;
            col_c     = '0;
            col_sub_c = '0;
        end
        in_cols_d = in_cols_c;
        col_d     = col_c;
        col_sub_d = col_sub_c;
        if (in_cols_c) begin
            if (col_sub_c == scale_d) begin
                col_sub_d = '0;
                if (col_c == COL_W'(SPR_W - 1)) in_cols_d = 1'b0;
                else                             col_d     = col_c + COL_W'(1);
            end else begin
                col_sub_d = col_sub_c + 2'd1;
            end
        end

        hit_c        = in_rows_d && in_cols_c && bus.blank;
        rom_addr_d   = ROM_AW'(frame_d) * ROM_AW'(FRAME_SZ)
                     + ROM_AW'(row_d) * ROM_AW'(SPR_W)
                     + ROM_AW'(col_c);
        v1_d         = hit_c;
        v2_d         = v1_q;
        pix_idx_d    = v2_q ? bus.rom_data : '0;
        pix_opaque_d = v2_q && (bus.rom_data != IDX_W'(KEY_IDX));
    end

    // prev_x resets to non-zero so a frame start right after reset is still detected.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            prev_x_q     <= '1;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            scale_q      <= '0;
            row_q        <= '0;
            row_sub_q    <= '0;
            in_rows_q    <= 1'b0;
            col_q        <= '0;
            col_sub_q    <= '0;
            in_cols_q    <= 1'b0;
            hold_q       <= '0;
            frame_q      <= '0;
            rom_addr_q   <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            pix_idx_q    <= '0;
            pix_opaque_q <= 1'b0;
        end else begin
            prev_x_q     <= prev_x_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            scale_q      <= scale_d;
            row_q        <= row_d;
            row_sub_q    <= row_sub_d;
            in_rows_q    <= in_rows_d;
            col_q        <= col_d;
            col_sub_q    <= col_sub_d;
            in_cols_q    <= in_cols_d;
            hold_q       <= hold_d;
            frame_q      <= frame_d;
            rom_addr_q   <= rom_addr_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            pix_idx_q    <= pix_idx_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.pix_idx    = pix_idx_q;
    assign bus.pix_opaque = pix_opaque_q;
    assign bus.anim_frame = frame_q;
endmodule

// File: tb/tb_sprite_layer_scaled.sv
// Bench for sprite_layer_scaled: compressed raster stimulus, an analytic geometry model
// checked every pixel, and hand-computed per-frame totals.
module tb_sprite_layer_scaled;
    localparam int unsigned SPR_W = 42, SPR_H = 44, IDX_W = 2, ROM_AW = 13, FRAME_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_layer_scaled_if #(.IDX_W(IDX_W), .ROM_AW(ROM_AW), .FRAME_W(FRAME_W)) bus ();

    sprite_layer_scaled #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(4), .IDX_W(IDX_W), .KEY_IDX(0), .ROM_AW(ROM_AW)
    ) dut (
        .vga_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    // Synchronous sprite ROM whose content is the low address bits.
    always_ff @(posedge clk) bus.rom_data <= bus.rom_addr[1:0];

    typedef struct { bit hit; int addr; int x; bit rst; } h_t;
    typedef struct {
        string nm;
        int px, py, sc, aen, hold, y_lo, y_hi, x_lo, x_hi, opq, first, af;
    } vec_t;

    h_t   h1, h2, h3;
    vec_t vq[$];
    int   n_tests = 0, n_fail = 0;
    int   m_px, m_py, m_sc, m_af, m_hold, prev_x;
    bit   m_ok;
    int   f_opq, f_lo, f_hi, f_post, f_first;
    bit   f_rst_seen;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // One pixel clock: check outputs for older pixels, then drive this pixel and model it.
    task automatic step(input int x, input int y, input bit r);
        h_t e;
        bit fs, blk;
        int w, h;
        @(negedge clk);
        if (h1.rst) begin
            chk("reset_rom_addr", int'(bus.rom_addr), 0);
            chk("reset_anim_frame", int'(bus.anim_frame), 0);
        end else if (h1.hit) begin
            chk("rom_addr", int'(bus.rom_addr), h1.addr);
            if (f_first < 0) f_first = int'(bus.rom_addr);
        end
        chk("pix_opaque", int'(bus.pix_opaque), (h3.hit && (h3.addr % 4 != 0)) ? 1 : 0);
        chk("pix_idx", int'(bus.pix_idx), h3.hit ? (h3.addr % 4) : 0);
        if (bus.pix_opaque) begin
            f_opq++;
            if (h3.x >= 300) f_hi++; else f_lo++;
            if (f_rst_seen) f_post++;
        end

        blk       = (x < 640) && (y < 480);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = blk;
        rst       = r;
        fs        = (x == 0) && (y == 0) && (prev_x != 0) && !r;
        if (r) begin
            m_ok = 0; m_px = 0; m_py = 0; m_sc = 0; m_af = 0; m_hold = 0;
            prev_x = 1023;
            f_rst_seen = 1;
        end else begin
            prev_x = x;
            if (fs) begin
                m_ok = 1;
                m_px = int'(bus.pos_x);
                m_py = int'(bus.pos_y);
                m_sc = int'(bus.scale);
                if (bus.anim_en) begin
                    if (m_hold == int'(bus.frame_hold)) begin
                        m_hold = 0;
                        m_af   = (m_af + 1) % 4;
                    end else begin
                        m_hold++;
                    end
                end
            end
        end
        w = SPR_W * (m_sc + 1);
        h = SPR_H * (m_sc + 1);
        e.hit  = !r && m_ok && blk && (x >= m_px) && (x < m_px + w) && (y >= m_py) && (y < m_py + h);
        e.addr = e.hit ? (m_af * SPR_W * SPR_H + ((y - m_py) / (m_sc + 1)) * SPR_W
                          + (x - m_px) / (m_sc + 1)) : 0;
        e.x    = x;
        e.rst  = r;
        if (r) begin
            h1.hit = 0;
            h2.hit = 0;
        end
        h3 = h2;
        h2 = h1;
        h1 = e;
    endtask

    // Compressed frame: line 0 then lines y_lo..y_hi, each as DrawX=0 followed by x_lo..x_hi.
    task automatic run_frame(input int y_lo, input int y_hi, input int x_lo, input int x_hi,
                             input int chg_y, input int chg_px, input int rst_y, input int rst_x);
        int xs;
        f_opq = 0; f_lo = 0; f_hi = 0; f_post = 0; f_first = -1; f_rst_seen = 0;
        xs = (x_lo < 1) ? 1 : x_lo;
        for (int y = (y_lo > 0) ? -1 : 0; y <= y_hi; y++) begin
            int yy;
            if (y < 0) yy = 0;
            else if (y_lo > 0 && y == 0) continue;
            else yy = (y_lo > 0) ? y : y;
            if (y >= 0 && y < y_lo) continue;
            if (yy == chg_y) bus.pos_x = 10'(chg_px);
            step(0, yy, (yy == rst_y) && (rst_x == 0));
            for (int x = xs; x <= x_hi; x++) step(x, yy, (yy == rst_y) && (x == rst_x));
        end
        for (int i = 1; i <= 4; i++) step(x_hi + i, y_hi, 1'b0);
    endtask

    task automatic add_vec(input string nm, input int px, input int py, input int sc,
                           input int aen, input int hold, input int y_lo, input int y_hi,
                           input int x_lo, input int x_hi, input int opq, input int first,
                           input int af);
        vec_t v;
        v.nm = nm; v.px = px; v.py = py; v.sc = sc; v.aen = aen; v.hold = hold;
        v.y_lo = y_lo; v.y_hi = y_hi; v.x_lo = x_lo; v.x_hi = x_hi;
        v.opq = opq; v.first = first; v.af = af;
        vq.push_back(v);
    endtask

    task automatic set_ctrl(input int px, input int py, input int sc, input int aen, input int hold);
        bus.pos_x      = 10'(px);
        bus.pos_y      = 10'(py);
        bus.scale      = 2'(sc);
        bus.anim_en    = aen[0];
        bus.frame_hold = 6'(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int af_seq[9];
        int first_seq[9];
        af_seq    = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        first_seq = '{0, 1848, 1848, 3696, 3696, 5544, 5544, 0, 0};

        add_vec("base_1x",      100,  50, 0, 0, 0,  45, 100,  95, 150,  1386,  0, 0);
        add_vec("scale_3x",       0,   0, 2, 0, 0,   0, 133,   0, 128, 12474,  0, 0);
        add_vec("scale_2x",       5,   2, 1, 0, 0,   0,  10,   0, 100,   566,  0, 0);
        for (int i = 0; i < 9; i++)
            add_vec($sformatf("anim_f%0d", i), 0, 0, 0, 1, 1, 0, 1, 0, 45, 63,
                    first_seq[i], af_seq[i]);
        add_vec("corner_clip",  620, 470, 0, 0, 0, 465, 485, 610, 660,   150,  0, 0);
        add_vec("offscreen_x",  700, 100, 0, 0, 0,  95, 110, 690, 760,     0, -1, 0);
        add_vec("offscreen_y",  100, 500, 0, 0, 0, 495, 505,  95, 150,     0, -1, 0);

        h1 = '{hit: 0, addr: 0, x: 0, rst: 0};
        h2 = h1;
        h3 = h1;
        m_ok = 0; m_px = 0; m_py = 0; m_sc = 0; m_af = 0; m_hold = 0; prev_x = 1023;
        rst = 1'b1;
        bus.DrawX = 10'd1; bus.DrawY = 10'd0; bus.blank = 1'b0;
        set_ctrl(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        step(1, 0, 1'b1);
        step(1, 0, 1'b1);
        chk("reset_pix_opaque", int'(bus.pix_opaque), 0);

        foreach (vq[i]) begin
            set_ctrl(vq[i].px, vq[i].py, vq[i].sc, vq[i].aen, vq[i].hold);
            run_frame(vq[i].y_lo, vq[i].y_hi, vq[i].x_lo, vq[i].x_hi, -1, 0, -1, 0);
            chk({vq[i].nm, "_opaque_count"}, f_opq, vq[i].opq);
            chk({vq[i].nm, "_first_addr"}, f_first, vq[i].first);
            chk({vq[i].nm, "_anim_frame"}, int'(bus.anim_frame), vq[i].af);
        end

        // pos_x moves mid-frame: current frame stays at 100, next frame renders at 300.
        set_ctrl(100, 190, 0, 0, 0);
        run_frame(190, 210, 95, 345, 200, 300, -1, 0);
        chk("midframe_opaque_count", f_opq, 661);
        chk("midframe_no_pixels_at_300", f_hi, 0);
        run_frame(190, 210, 95, 345, -1, 0, -1, 0);
        chk("moved_opaque_count", f_opq, 661);
        chk("moved_no_pixels_at_100", f_lo, 0);
        chk("moved_first_addr", f_first, 0);

        // One-cycle reset inside the sprite, then a clean frame.
        set_ctrl(100, 230, 0, 1, 1);
        run_frame(230, 245, 95, 150, -1, 0, 240, 110);
        chk("rstframe_first_addr", f_first, 1848);
        chk("rstframe_opaque_count", f_opq, 321);
        chk("rstframe_opaque_after_reset", f_post, 0);
        chk("rstframe_anim_frame", int'(bus.anim_frame), 0);
        set_ctrl(100, 230, 0, 0, 1);
        run_frame(230, 245, 95, 150, -1, 0, -1, 0);
        chk("after_rst_opaque_count", f_opq, 504);
        chk("after_rst_first_addr", f_first, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
